// File: rtl/ibus_uncache_bridge_pkg.sv
// rtl/ibus_uncache_bridge_pkg.sv - shared types and AXI constants for the uncached fetch bridge
//
// Purpose : FSM state encoding, AXI burst/size/response constants and a
//           helper that classifies an AXI read response as an error.
// Ports   : none (package).
package ibus_uncache_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } ibus_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // SLVERR and DECERR are exactly the responses with bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/ibus_uncache_bridge.sv
// rtl/ibus_uncache_bridge.sv - single-beat AXI4 read bridge for uncached instruction fetch
//
// Purpose : accepts one fetch request at a time from IF, issues one AXI
//           single-beat 32-bit read, and holds the returned word and error
//           flag in a one-entry buffer until IF consumes it.
// Ports   :
//   clk, resetn                       core clock, async active-low reset
//   flush                             IF flush (drops in-flight or buffered fetch)
//   cpu_valid/cpu_addr/cpu_ready      fetch request handshake
//   cpu_rvalid/cpu_rready             response handshake
//   cpu_rdata/cpu_rerr                instruction word and bus-error flag
//   arid/araddr/arlen/arsize/arburst  AXI AR payload (constant except araddr)
//   arvalid/arready                   AXI AR handshake
//   rid/rdata/rresp/rlast             AXI R payload (rid and rlast unused)
//   rvalid/rready                     AXI R handshake
module ibus_uncache_bridge
  import ibus_uncache_bridge_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            cpu_valid,
  input  logic [31:0]     cpu_addr,
  output logic            cpu_ready,
  output logic            cpu_rvalid,
  input  logic            cpu_rready,
  output logic [31:0]     cpu_rdata,
  output logic            cpu_rerr,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);

  ibus_state_t r_state;
  ibus_state_t w_state_nxt;
  logic        r_drop;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  logic        r_rerr;
  logic        w_accept;
  logic        w_drop;

  // rid/rlast carry no information for a single-beat, single-ID master.
  logic w_unused;
  assign w_unused = ^{rid, rlast, rresp[0], cpu_addr[1:0]};

  assign w_accept = (r_state == IDLE) & cpu_valid & ~flush;
  // A flush arriving with the R beat must drop it, so include the live flush.
  assign w_drop   = r_drop | flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cpu_ready   = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    cpu_rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (w_accept) w_state_nxt = ADDR;
      end
      ADDR: begin
        // arvalid is never withdrawn, even after a flush.
        arvalid = 1'b1;
        if (arready) w_state_nxt = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (rvalid) w_state_nxt = w_drop ? IDLE : RESP;
      end
      RESP: begin
        cpu_rvalid = 1'b1;
        if (cpu_rready | flush) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop   <= 1'b0;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      if (flush && (r_state == ADDR || r_state == DATA)) r_drop <= 1'b1;
      if (w_state_nxt == IDLE) r_drop <= 1'b0;
      if (w_accept) r_araddr <= {cpu_addr[31:2], 2'b00};
      if (r_state == DATA && rvalid && !w_drop) begin
        r_rdata <= rdata;
        r_rerr  <= resp_is_err(rresp);
      end
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_rerr  = r_rerr;
  assign araddr    = r_araddr;
  assign arid      = AXI_ID;
  assign arlen     = 8'd0;
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;

endmodule

// File: tb/tb_ibus_uncache_bridge.sv
// tb/tb_ibus_uncache_bridge.sv - self-checking bench for ibus_uncache_bridge
module tb_ibus_uncache_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic        cpu_rready;
  logic [31:0] cpu_rdata;
  logic        cpu_rerr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  ibus_uncache_bridge #(.ID_W(4), .AXI_ID(4'h0)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_rvalid(cpu_rvalid), .cpu_rready(cpu_rready),
    .cpu_rdata(cpu_rdata), .cpu_rerr(cpu_rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 flush in ADDR, 2 flush in DATA before beat,
  //       3 flush with the R beat, 4 flush instead of cpu_rready in RESP
  task automatic fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                       input logic [31:0] data, input logic [1:0] resp,
                       input int stall, input int mode);
    logic [31:0] exp_addr;
    logic        exp_err;
    bit          dropped;
    exp_addr = addr - (addr % 32'd4);
    exp_err  = (resp == 2'd2) || (resp == 2'd3);
    dropped  = (mode >= 1) && (mode <= 3);

    chk("idle_cpu_ready", cpu_ready, 1);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    step();
    cpu_valid = 1'b0;
    cpu_addr  = $urandom;
    chk("addr_arvalid", arvalid, 1);
    chk("addr_araddr", araddr, exp_addr);
    chk("addr_arlen", arlen, 0);
    chk("addr_cpu_ready", cpu_ready, 0);
    if (mode == 1) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("addr_hold_after_flush", arvalid, 1);
    end
    for (int i = 0; i < ar_wait; i++) begin
      cpu_addr = $urandom;
      step();
      chk("addr_wait_arvalid", arvalid, 1);
      chk("addr_wait_araddr", araddr, exp_addr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("data_rready", rready, 1);
    chk("data_arvalid", arvalid, 0);
    chk("data_cpu_rvalid", cpu_rvalid, 0);
    if (mode == 2) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("data_rready_after_flush", rready, 1);
    end
    for (int i = 0; i < r_wait; i++) begin
      rdata = $urandom;
      step();
      chk("data_wait_rready", rready, 1);
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    if (mode == 3) flush = 1'b1;
    step();
    rvalid = 1'b0;
    flush  = 1'b0;
    rdata  = $urandom;
    rresp  = 2'($urandom);
    if (dropped) begin
      chk("drop_cpu_rvalid", cpu_rvalid, 0);
      chk("drop_cpu_ready", cpu_ready, 1);
      return;
    end
    chk("resp_cpu_rvalid", cpu_rvalid, 1);
    chk("resp_cpu_rdata", cpu_rdata, data);
    chk("resp_cpu_rerr", cpu_rerr, exp_err);
    chk("resp_rready", rready, 0);
    for (int i = 0; i < stall; i++) begin
      rdata = $urandom;
      step();
      chk("stall_cpu_rvalid", cpu_rvalid, 1);
      chk("stall_cpu_rdata", cpu_rdata, data);
      chk("stall_cpu_rerr", cpu_rerr, exp_err);
    end
    if (mode == 4) flush = 1'b1;
    else cpu_rready = 1'b1;
    step();
    flush      = 1'b0;
    cpu_rready = 1'b0;
    chk("done_cpu_ready", cpu_ready, 1);
    chk("done_cpu_rvalid", cpu_rvalid, 0);
  endtask

  initial begin
    resetn     = 1'b0;
    flush      = 1'b0;
    cpu_valid  = 1'b0;
    cpu_addr   = '0;
    cpu_rready = 1'b0;
    arready    = 1'b0;
    rid        = '0;
    rdata      = '0;
    rresp      = '0;
    rlast      = 1'b1;
    rvalid     = 1'b0;
    step();
    step();

    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_rerr", cpu_rerr, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arid", arid, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 3'b010);
    chk("rst_arburst", arburst, 2'b01);
    resetn = 1'b1;
    step();

    // Minimum-latency single fetch.
    fetch(32'hBFC0_0004, 0, 0, 32'h2408_0001, 2'b00, 0, 0);
    // Misaligned address, AR backpressure.
    fetch(32'hBFC0_0007, 5, 0, 32'h1234_5678, 2'b00, 0, 0);
    // Flush in DATA before the beat.
    fetch(32'h8000_0010, 0, 2, 32'hDEAD_BEEF, 2'b00, 0, 2);
    // Stalled IF.
    fetch(32'h8000_0020, 1, 1, 32'hCAFE_F00D, 2'b00, 10, 0);
    // DECERR and SLVERR.
    fetch(32'h1FC0_0000, 0, 0, 32'h0BAD_0BAD, 2'b11, 1, 0);
    fetch(32'h1FC0_0008, 0, 0, 32'h5555_AAAA, 2'b10, 0, 0);
    // Flush in ADDR, with the beat, and in RESP.
    fetch(32'h0000_0100, 2, 0, 32'h1111_2222, 2'b00, 0, 1);
    fetch(32'h0000_0200, 0, 1, 32'h3333_4444, 2'b00, 0, 3);
    fetch(32'h0000_0300, 0, 0, 32'h5555_6666, 2'b01, 2, 4);

    // Flush and cpu_valid together in IDLE: not accepted.
    cpu_valid = 1'b1;
    flush     = 1'b1;
    cpu_addr  = 32'hFFFF_FFF0;
    step();
    cpu_valid = 1'b0;
    flush     = 1'b0;
    chk("idle_flush_arvalid", arvalid, 0);
    chk("idle_flush_cpu_ready", cpu_ready, 1);

    // Randomized fetches against the model inside fetch().
    for (int n = 0; n < 24; n++) begin
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Asynchronous reset while in DATA.
    cpu_valid = 1'b1;
    cpu_addr  = 32'hABCD_0000;
    step();
    cpu_valid = 1'b0;
    arready   = 1'b1;
    step();
    arready   = 1'b0;
    chk("pre_reset_rready", rready, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_cpu_ready", cpu_ready, 1);
    chk("areset_rready", rready, 0);
    chk("areset_arvalid", arvalid, 0);
    chk("areset_cpu_rvalid", cpu_rvalid, 0);
    chk("areset_araddr", araddr, 0);
    chk("areset_cpu_rdata", cpu_rdata, 0);
    chk("areset_cpu_rerr", cpu_rerr, 0);
    step();
    resetn = 1'b1;
    step();
    fetch(32'hBFC0_0380, 0, 0, 32'h7777_8888, 2'b00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
